// File: rtl/mipi_tx_lane_distributor_if.sv
// Word-in / lane-out bus of the MIPI HS transmit lane distributor.
// The source drives the word side (master); the distributor drives the lane side (slave).
interface mipi_tx_lane_distributor_if;
   logic [31:0] byte_i;
   logic        byte_valid_i;
   logic        packet_last_i;
   logic        ready_o;
   logic [31:0] lane_byte_o;
   logic [3:0]  lane_valid_o;
   logic        busy_o;
   logic        underflow_o;

   modport master (
      output byte_i,
      output byte_valid_i,
      output packet_last_i,
      input  ready_o,
      input  lane_byte_o,
      input  lane_valid_o,
      input  busy_o,
      input  underflow_o
   );

   modport slave (
      input  byte_i,
      input  byte_valid_i,
      input  packet_last_i,
      output ready_o,
      output lane_byte_o,
      output lane_valid_o,
      output busy_o,
      output underflow_o
   );
endinterface

// File: rtl/mipi_tx_lane_distributor.sv
// MIPI HS transmit lane distributor: splits 32-bit packet words over four byte lanes,
// framing each packet with a prepare gap, a sync byte and per-lane HS-trail bytes.
// Every output is a flop; the next-cycle values are decoded from the next state.
module mipi_tx_lane_distributor #(
   parameter int unsigned PREP_CYCLES = 3,
   parameter int unsigned TRAIL_BYTES = 2
) (
   input logic                        clk_i,
   input logic                        reset_i,
   mipi_tx_lane_distributor_if.slave  bus
);

   typedef enum logic [2:0] {StIdle, StPrep, StSync, StData, StTrail} state_e;

   localparam logic [31:0] SyncWord = 32'hB8B8_B8B8;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] last_q, last_d;
   logic [31:0] lane_byte_q, lane_byte_d;
   logic [3:0]  lane_valid_q, lane_valid_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        underflow_q, underflow_d;
   logic        accept;

   assign accept = bus.byte_valid_i & ready_q;

   // Next state, counters, last-byte latch and the registered output values.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_d       = last_q;
      underflow_d  = underflow_q;
      ready_d      = 1'b0;
      lane_valid_d = 4'h0;
      lane_byte_d  = 32'h0;

      unique case (state_q)
         StIdle: begin
            if (bus.byte_valid_i) begin
               state_d     = StPrep;
               cnt_d       = 4'(PREP_CYCLES);
               underflow_d = 1'b0;
            end
         end
         StPrep: begin
            if (cnt_q <= 4'd1) begin
               state_d = StSync;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StSync: begin
            state_d = StData;
         end
         StData: begin
            // ready_q low means the final word is on the lanes right now.
            if (!ready_q) begin
               state_d = StTrail;
               cnt_d   = 4'(TRAIL_BYTES);
            end else if (!bus.byte_valid_i) begin
               underflow_d = 1'b1;
            end
         end
         StTrail: begin
            if (cnt_q <= 4'd1) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         last_d = bus.byte_i;
      end

      case (state_d)
         StSync: begin
            ready_d      = 1'b1;
            lane_valid_d = 4'hF;
            lane_byte_d  = SyncWord;
         end
         StData: begin
            // Only reachable while ready_q is high; a starved cycle sends zeros.
            lane_valid_d = 4'hF;
            if (accept) begin
               lane_byte_d = bus.byte_i;
               ready_d     = ~bus.packet_last_i;
            end else begin
               ready_d = 1'b1;
            end
         end
         StTrail: begin
            lane_valid_d = 4'hF;
            // Trail level is the inverse of the last serialised (MSB) bit of each lane.
            for (int k = 0; k < 4; k++) begin
               lane_byte_d[8*k +: 8] = last_q[8*k + 7] ? 8'h00 : 8'hFF;
            end
         end
         default: ;
      endcase

      busy_d = (state_d != StIdle);
   end

   // State and output registers, cleared asynchronously by reset_i.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         cnt_q        <= 4'h0;
         last_q       <= 32'h0;
         lane_byte_q  <= 32'h0;
         lane_valid_q <= 4'h0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_q       <= last_d;
         lane_byte_q  <= lane_byte_d;
         lane_valid_q <= lane_valid_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         underflow_q  <= underflow_d;
      end
   end

   assign bus.ready_o      = ready_q;
   assign bus.lane_byte_o  = lane_byte_q;
   assign bus.lane_valid_o = lane_valid_q;
   assign bus.busy_o       = busy_q;
   assign bus.underflow_o  = underflow_q;

endmodule

// File: tb/tb_mipi_tx_lane_distributor.sv
// Directed bench for the MIPI TX lane distributor. Each table row holds the inputs driven
// during one clock cycle together with the outputs expected during that same cycle.
module tb_mipi_tx_lane_distributor;

   typedef struct {
      logic        valid;
      logic        last;
      logic [31:0] data;
      logic        exp_ready;
      logic [3:0]  exp_lv;
      logic [31:0] exp_lb;
      logic        exp_busy;
      logic        exp_uf;
   } vec_t;

   logic clk_i;
   logic reset_i;
   int   checks;
   int   errors;
   int   phase2_start;
   vec_t tbl[$];

   mipi_tx_lane_distributor_if bus_if ();

   mipi_tx_lane_distributor #(
      .PREP_CYCLES (3),
      .TRAIL_BYTES (2)
   ) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus_if)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic add(input logic v, input logic l, input logic [31:0] d, input logic r,
                      input logic [3:0] lv, input logic [31:0] lb, input logic bz,
                      input logic uf);
      vec_t e;
      e.valid = v; e.last = l; e.data = d;
      e.exp_ready = r; e.exp_lv = lv; e.exp_lb = lb; e.exp_busy = bz; e.exp_uf = uf;
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (vector %0d): got %h, expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic l, input logic [31:0] d);
      bus_if.byte_valid_i  = v;
      bus_if.packet_last_i = l;
      bus_if.byte_i        = d;
   endtask

   task automatic check_outputs(input int idx, input logic r, input logic [3:0] lv,
                                input logic [31:0] lb, input logic bz, input logic uf);
      chk("ready_o", idx, 32'(bus_if.ready_o), 32'(r));
      chk("lane_valid_o", idx, 32'(bus_if.lane_valid_o), 32'(lv));
      chk("lane_byte_o", idx, bus_if.lane_byte_o, lb);
      chk("busy_o", idx, 32'(bus_if.busy_o), 32'(bz));
      chk("underflow_o", idx, 32'(bus_if.underflow_o), 32'(uf));
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         @(posedge clk_i);
         #1;
         check_outputs(i, tbl[i].exp_ready, tbl[i].exp_lv, tbl[i].exp_lb, tbl[i].exp_busy,
                       tbl[i].exp_uf);
         drive(tbl[i].valid, tbl[i].last, tbl[i].data);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Basic three-word packet.
      add(1, 0, 32'h1111_1111, 0, 4'h0, 32'h0, 0, 0);
      repeat (3) add(1, 0, 32'h1111_1111, 0, 4'h0, 32'h0, 1, 0);
      add(1, 0, 32'h1111_1111, 1, 4'hF, 32'hB8B8_B8B8, 1, 0);
      add(1, 0, 32'h2222_2222, 1, 4'hF, 32'h1111_1111, 1, 0);
      add(1, 1, 32'h3333_3333, 1, 4'hF, 32'h2222_2222, 1, 0);
      add(0, 0, 32'h0, 0, 4'hF, 32'h3333_3333, 1, 0);
      repeat (2) add(0, 0, 32'h0, 0, 4'hF, 32'hFFFF_FFFF, 1, 0);
      add(0, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
      // Mixed trail: only the final word sets the trail levels.
      add(1, 0, 32'h1234_5678, 0, 4'h0, 32'h0, 0, 0);
      repeat (3) add(1, 0, 32'h1234_5678, 0, 4'h0, 32'h0, 1, 0);
      add(1, 0, 32'h1234_5678, 1, 4'hF, 32'hB8B8_B8B8, 1, 0);
      add(1, 1, 32'h80FF_0001, 1, 4'hF, 32'h1234_5678, 1, 0);
      add(0, 0, 32'h0, 0, 4'hF, 32'h80FF_0001, 1, 0);
      repeat (2) add(0, 0, 32'h0, 0, 4'hF, 32'h0000_FFFF, 1, 0);
      // Underflow mid-packet; the byte_i garbage without valid must be ignored.
      add(1, 0, 32'h0102_0304, 0, 4'h0, 32'h0, 0, 0);
      repeat (3) add(1, 0, 32'h0102_0304, 0, 4'h0, 32'h0, 1, 0);
      add(1, 0, 32'h0102_0304, 1, 4'hF, 32'hB8B8_B8B8, 1, 0);
      add(0, 1, 32'hDEAD_BEEF, 1, 4'hF, 32'h0102_0304, 1, 0);
      add(1, 1, 32'h0A0B_0C0D, 1, 4'hF, 32'h0000_0000, 1, 1);
      add(0, 0, 32'h0, 0, 4'hF, 32'h0A0B_0C0D, 1, 1);
      repeat (2) add(0, 0, 32'h0, 0, 4'hF, 32'hFFFF_FFFF, 1, 1);
      // Single-word packet; underflow clears on entering PREP.
      add(1, 1, 32'hAAAA_AAAA, 0, 4'h0, 32'h0, 0, 1);
      repeat (3) add(1, 1, 32'hAAAA_AAAA, 0, 4'h0, 32'h0, 1, 0);
      add(1, 1, 32'hAAAA_AAAA, 1, 4'hF, 32'hB8B8_B8B8, 1, 0);
      add(0, 0, 32'h0, 0, 4'hF, 32'hAAAA_AAAA, 1, 0);
      repeat (2) add(0, 0, 32'h0, 0, 4'hF, 32'h0000_0000, 1, 0);
      // Back-to-back: valid held high through TRAIL, then an IDLE gap and a new packet.
      add(1, 1, 32'h5A5A_5A5A, 0, 4'h0, 32'h0, 0, 0);
      repeat (3) add(1, 1, 32'h5A5A_5A5A, 0, 4'h0, 32'h0, 1, 0);
      add(1, 1, 32'h5A5A_5A5A, 1, 4'hF, 32'hB8B8_B8B8, 1, 0);
      add(1, 1, 32'h5A5A_5A5A, 0, 4'hF, 32'h5A5A_5A5A, 1, 0);
      repeat (2) add(1, 1, 32'h5A5A_5A5A, 0, 4'hF, 32'hFFFF_FFFF, 1, 0);
      add(1, 0, 32'hC3C3_C3C3, 0, 4'h0, 32'h0, 0, 0);
      repeat (3) add(1, 0, 32'hC3C3_C3C3, 0, 4'h0, 32'h0, 1, 0);
      add(1, 0, 32'hC3C3_C3C3, 1, 4'hF, 32'hB8B8_B8B8, 1, 0);
      add(1, 0, 32'h3C3C_3C3C, 1, 4'hF, 32'hC3C3_C3C3, 1, 0);
      add(1, 0, 32'h7777_7777, 1, 4'hF, 32'h3C3C_3C3C, 1, 0);
      phase2_start = tbl.size();
      // After the mid-packet reset: waits in IDLE, then a clean packet.
      add(0, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0);
      add(1, 1, 32'h0F0F_0F0F, 0, 4'h0, 32'h0, 0, 0);
      repeat (3) add(1, 1, 32'h0F0F_0F0F, 0, 4'h0, 32'h0, 1, 0);
      add(1, 1, 32'h0F0F_0F0F, 1, 4'hF, 32'hB8B8_B8B8, 1, 0);
      add(0, 0, 32'h0, 0, 4'hF, 32'h0F0F_0F0F, 1, 0);
      repeat (2) add(0, 0, 32'h0, 0, 4'hF, 32'hFFFF_FFFF, 1, 0);
      add(0, 0, 32'h0, 0, 4'h0, 32'h0, 0, 0);

      reset_i = 1'b1;
      drive(1'b0, 1'b0, 32'h0);
      repeat (2) @(posedge clk_i);
      #1;
      check_outputs(-1, 0, 4'h0, 32'h0, 0, 0);
      #2 reset_i = 1'b0;

      run_range(0, phase2_start);

      // Asynchronous reset in DATA after two words: outputs clear without waiting for a clock.
      #2 reset_i = 1'b1;
      drive(1'b0, 1'b0, 32'h0);
      #1;
      check_outputs(-2, 0, 4'h0, 32'h0, 0, 0);
      repeat (2) @(posedge clk_i);
      #3 reset_i = 1'b0;

      run_range(phase2_start, tbl.size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
